// File: rtl/tcb_pkg.sv
// Shared definitions for the ternary dense-layer engine.
//   TCB_*     : 2-bit ternary weight codes
//   tcb_state_t : engine sequencing states
//   tcb_mul   : ternary code times a sign-extended operand
package tcb_pkg;

  localparam logic [1:0] TCB_ZERO = 2'b00;
  localparam logic [1:0] TCB_POS  = 2'b01;
  localparam logic [1:0] TCB_RSVD = 2'b10;
  localparam logic [1:0] TCB_NEG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ARG  = 2'd2,
    DONE = 2'd3
  } tcb_state_t;

  // Wide operand so one function serves every IN_W/ACC_W; the caller
  // truncates to its accumulator width (wrap-around is intended).
  // The reserved code must never inject a value, so it maps to zero.
  function automatic logic signed [63:0] tcb_mul(input logic [1:0] code,
                                                 input logic signed [63:0] x);
    case (code)
      TCB_POS:  return x;
      TCB_NEG:  return -x;
      TCB_ZERO: return '0;
      TCB_RSVD: return '0;
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/tcb_weight_ram.sv
// Ternary weight store: N_IN rows of 2*N_OUT bits (one code per neuron).
// Contents are deliberately not reset so loaded layers survive rst.
//   clk     : clock
//   wr_en   : write strobe (already gated by the engine's idle state)
//   wr_addr : row index; rows >= N_IN are ignored
//   wr_data : row contents, neuron j at [2j +: 2]
//   rd_addr : row index for the combinational read port
//   rd_data : row contents at rd_addr
module tcb_weight_ram #(
  parameter int N_IN   = 121,
  parameter int N_OUT  = 16,
  parameter int ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [2*N_OUT-1:0]   wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [2*N_OUT-1:0]   rd_data
);

  logic [2*N_OUT-1:0] mem [N_IN];

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < N_IN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The engine indexes one row per ACC cycle; a combinational read lets
  // a row written on the accepting edge be used by that same transaction.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tcb_dense_argmax.sv
// Ternary fully-connected layer with sequential argmax.
// One input vector is accepted over valid/ready, streamed one element per
// cycle through N_OUT parallel accumulators, then the sums are scanned for
// the maximum (ties keep the lowest index). Results are held until consumed.
//   clk, rst   : clock, synchronous active-high reset
//   in_vec     : input vector, element i at [i*IN_W +: IN_W]
//   in_valid / in_ready   : input handshake (ready only when idle)
//   wr_en / wr_addr / wr_data / wr_ready : weight row write port
//   out_vec    : signed sums, neuron j at [j*ACC_W +: ACC_W]
//   out_idx    : argmax neuron index
//   out_valid / out_ready : result handshake
module tcb_dense_argmax
  import tcb_pkg::*;
#(
  parameter int N_IN      = 121,
  parameter int N_OUT     = 16,
  parameter int IN_W      = 8,
  parameter int IN_SIGNED = 0,
  parameter int ACC_W     = IN_W + $clog2(N_IN) + 1,
  parameter int IDX_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int ADDR_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN*IN_W-1:0]     in_vec,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [2*N_OUT-1:0]       wr_data,
  output logic                     wr_ready,
  output logic [N_OUT*ACC_W-1:0]   out_vec,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_valid,
  input  logic                     out_ready
);

  tcb_state_t              state_reg;
  logic [ADDR_W-1:0]       i_reg;
  logic [IDX_W-1:0]        k_reg;
  logic [IN_W-1:0]         x_reg [N_IN];
  logic signed [ACC_W-1:0] acc_reg [N_OUT];
  logic signed [ACC_W-1:0] acc_next [N_OUT];
  logic signed [ACC_W-1:0] best_val_reg;
  logic [IDX_W-1:0]        best_idx_reg;
  logic [2*N_OUT-1:0]      w_row;
  logic [IN_W-1:0]         x_cur;
  logic signed [63:0]      x_ext;
  logic                    accept;
  logic                    last_in;
  logic                    last_out;

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign wr_ready  = (state_reg == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign out_idx   = best_idx_reg;
  assign last_in   = (i_reg == ADDR_W'(N_IN - 1));
  assign last_out  = (k_reg == IDX_W'(N_OUT - 1));

  tcb_weight_ram #(
    .N_IN   (N_IN),
    .N_OUT  (N_OUT),
    .ADDR_W (ADDR_W)
  ) u_wram (
    .clk     (clk),
    .wr_en   (wr_en && wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (i_reg),
    .rd_data (w_row)
  );

  assign x_cur = x_reg[i_reg];

  always_comb begin
    if (IN_SIGNED != 0) begin
      x_ext = {{(64-IN_W){x_cur[IN_W-1]}}, x_cur};
    end else begin
      x_ext = {{(64-IN_W){1'b0}}, x_cur};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_neuron
      assign acc_next[gi] = acc_reg[gi] + ACC_W'(tcb_mul(w_row[2*gi +: 2], x_ext));
      assign out_vec[gi*ACC_W +: ACC_W] = acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      i_reg        <= '0;
      k_reg        <= '0;
      best_idx_reg <= '0;
      best_val_reg <= '0;
      for (int j = 0; j < N_OUT; j++) acc_reg[j] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            for (int n = 0; n < N_IN; n++) x_reg[n] <= in_vec[n*IN_W +: IN_W];
            for (int j = 0; j < N_OUT; j++) acc_reg[j] <= '0;
            i_reg     <= '0;
            state_reg <= ACC;
          end
        end
        ACC: begin
          for (int j = 0; j < N_OUT; j++) acc_reg[j] <= acc_next[j];
          i_reg <= i_reg + 1'b1;
          if (last_in) begin
            // Seed the scan with neuron 0's final sum (not the stale register).
            i_reg        <= '0;
            best_idx_reg <= '0;
            best_val_reg <= acc_next[0];
            k_reg        <= IDX_W'(1);
            state_reg    <= (N_OUT > 1) ? ARG : DONE;
          end
        end
        ARG: begin
          // Strict compare: equal sums keep the earlier (lower) index.
          if (acc_reg[k_reg] > best_val_reg) begin
            best_idx_reg <= k_reg;
            best_val_reg <= acc_reg[k_reg];
          end
          k_reg <= k_reg + 1'b1;
          if (last_out) begin
            k_reg     <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcb_dense_argmax.sv
// Directed bench: a small 4x3 instance driven from a vector table plus
// hand-written sequences (backpressure, busy writes, mid-run reset), and two
// 121x16 instances (unsigned and signed inputs) for full-size runs.
module tb_tcb_dense_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- small instance: N_IN=4, N_OUT=3, ACC_W=11 -------------
  localparam int S_ACC = 11;
  logic [31:0]        s_in_vec;
  logic               s_in_valid, s_in_ready;
  logic               s_wr_en, s_wr_ready;
  logic [1:0]         s_wr_addr;
  logic [5:0]         s_wr_data;
  logic [3*S_ACC-1:0] s_out_vec;
  logic [1:0]         s_out_idx;
  logic               s_out_valid, s_out_ready;

  tcb_dense_argmax #(.N_IN(4), .N_OUT(3)) u_small (
    .clk(clk), .rst(rst),
    .in_vec(s_in_vec), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
    .out_vec(s_out_vec), .out_idx(s_out_idx), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  // ---------------- large instances: N_IN=121, N_OUT=16, ACC_W=16 ----------
  logic [121*8-1:0] l_in_vec;
  logic [6:0]       l_wr_addr;
  logic [31:0]      l_wr_data;
  logic             l_in_valid, l_wr_en, l_out_ready;
  bit               lsel;  // 0 = unsigned instance, 1 = signed instance

  logic d_in_valid, d_in_ready, d_wr_en, d_wr_ready, d_out_valid, d_out_ready;
  logic g_in_valid, g_in_ready, g_wr_en, g_wr_ready, g_out_valid, g_out_ready;
  logic [255:0] d_out_vec, g_out_vec;
  logic [3:0]   d_out_idx, g_out_idx;

  assign d_in_valid  = l_in_valid  && !lsel;
  assign g_in_valid  = l_in_valid  &&  lsel;
  assign d_wr_en     = l_wr_en     && !lsel;
  assign g_wr_en     = l_wr_en     &&  lsel;
  assign d_out_ready = l_out_ready && !lsel;
  assign g_out_ready = l_out_ready &&  lsel;

  logic         l_in_ready, l_wr_ready, l_out_valid;
  logic [255:0] l_out_vec;
  logic [3:0]   l_out_idx;
  assign l_in_ready  = lsel ? g_in_ready  : d_in_ready;
  assign l_wr_ready  = lsel ? g_wr_ready  : d_wr_ready;
  assign l_out_valid = lsel ? g_out_valid : d_out_valid;
  assign l_out_vec   = lsel ? g_out_vec   : d_out_vec;
  assign l_out_idx   = lsel ? g_out_idx   : d_out_idx;

  tcb_dense_argmax u_def (
    .clk(clk), .rst(rst),
    .in_vec(l_in_vec), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .wr_en(d_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data), .wr_ready(d_wr_ready),
    .out_vec(d_out_vec), .out_idx(d_out_idx), .out_valid(d_out_valid), .out_ready(d_out_ready)
  );

  tcb_dense_argmax #(.IN_SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst),
    .in_vec(l_in_vec), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .wr_en(g_wr_en), .wr_addr(l_wr_addr), .wr_data(l_wr_data), .wr_ready(g_wr_ready),
    .out_vec(g_out_vec), .out_idx(g_out_idx), .out_valid(g_out_valid), .out_ready(g_out_ready)
  );

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint s_lane(input int j);
    return longint'($signed(s_out_vec[j*S_ACC +: S_ACC]));
  endfunction

  function automatic longint l_lane(input int j);
    return longint'($signed(l_out_vec[j*16 +: 16]));
  endfunction

  // ---------------- small-instance tasks -----------------------------------
  task automatic s_write(input logic [1:0] addr, input logic [5:0] data, input bit exp_rdy);
    @(negedge clk);
    s_wr_en = 1'b1; s_wr_addr = addr; s_wr_data = data;
    #1 chk("s_wr_ready", longint'(s_wr_ready), longint'(exp_rdy));
    @(posedge clk);
    #1 s_wr_en = 1'b0;
  endtask

  // nw[j][2i +: 2] = code of neuron j for input i
  task automatic s_load(input logic [2:0][7:0] nw);
    logic [5:0] row;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) row[2*j +: 2] = nw[j][2*i +: 2];
      s_write(2'(i), row, 1'b1);
    end
  endtask

  task automatic s_start(input logic [31:0] x);
    @(negedge clk);
    s_in_vec = x; s_in_valid = 1'b1;
    #1 chk("s_in_ready", longint'(s_in_ready), 1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    s_in_vec = ~x;  // later changes must not affect the transaction
  endtask

  // Count edges from the accepting edge until out_valid; 'skip' edges
  // have already elapsed in the caller.
  task automatic s_wait(input int exp_lat, input int skip);
    int lat = 0;
    for (int n = skip + 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (s_out_valid) begin lat = n; break; end
    end
    chk("s_latency", lat, exp_lat);
  endtask

  task automatic s_check(input string tag, input int e0, input int e1, input int e2, input int eidx);
    chk({tag, ".lane0"}, s_lane(0), e0);
    chk({tag, ".lane1"}, s_lane(1), e1);
    chk({tag, ".lane2"}, s_lane(2), e2);
    chk({tag, ".idx"}, longint'(s_out_idx), eidx);
    $display("txn %s: sums [%0d %0d %0d] idx %0d", tag, s_lane(0), s_lane(1), s_lane(2), s_out_idx);
  endtask

  task automatic s_release();
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1 s_out_ready = 1'b0;
    chk("s_release.out_valid", longint'(s_out_valid), 0);
    chk("s_release.in_ready", longint'(s_in_ready), 1);
  endtask

  // ---------------- large-instance tasks -----------------------------------
  task automatic l_write(input logic [6:0] addr, input logic [31:0] data);
    @(negedge clk);
    l_wr_en = 1'b1; l_wr_addr = addr; l_wr_data = data;
    #1 chk("l_wr_ready", longint'(l_wr_ready), 1);
    @(posedge clk);
    #1 l_wr_en = 1'b0;
  endtask

  task automatic l_run(input string tag, input logic [121*8-1:0] x,
                       input int e0, input int e1, input int erest, input int eidx);
    int lat = 0;
    @(negedge clk);
    l_in_vec = x; l_in_valid = 1'b1;
    #1 chk({tag, ".in_ready"}, longint'(l_in_ready), 1);
    @(posedge clk);
    #1 l_in_valid = 1'b0;
    l_in_vec = '0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (l_out_valid) begin lat = n; break; end
    end
    chk({tag, ".latency"}, lat, 136);
    chk({tag, ".lane0"}, l_lane(0), e0);
    chk({tag, ".lane1"}, l_lane(1), e1);
    for (int j = 2; j < 16; j++) chk($sformatf("%s.lane%0d", tag, j), l_lane(j), erest);
    chk({tag, ".idx"}, longint'(l_out_idx), eidx);
    $display("txn %s: lane0 %0d lane1 %0d lane15 %0d idx %0d latency %0d",
             tag, l_lane(0), l_lane(1), l_lane(15), l_out_idx, lat);
    @(negedge clk);
    l_out_ready = 1'b1;
    @(posedge clk);
    #1 l_out_ready = 1'b0;
    chk({tag, ".release"}, longint'(l_in_ready), 1);
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic [2:0][7:0] nw;
    logic [3:0][7:0] x;
    int e0, e1, e2, eidx;
  } svec_t;

  svec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // x=[1,2,3,4]; n0 all +1, n1 all -1, n2 codes [01,00,11,01]
    tbl[0] = '{nw: {8'h71, 8'hFF, 8'h55}, x: {8'd4, 8'd3, 8'd2, 8'd1}, e0: 10,    e1: -10, e2: 2,    eidx: 0};
    // neuron0 and neuron2 swapped
    tbl[1] = '{nw: {8'h55, 8'hFF, 8'h71}, x: {8'd4, 8'd3, 8'd2, 8'd1}, e0: 2,     e1: -10, e2: 10,   eidx: 2};
    // three-way tie resolves to lowest index
    tbl[2] = '{nw: {8'h55, 8'h55, 8'h55}, x: {8'd4, 8'd3, 8'd2, 8'd1}, e0: 10,    e1: 10,  e2: 10,   eidx: 0};
    // reserved code contributes nothing; 0 == 0 tie keeps index 0
    tbl[3] = '{nw: {8'h00, 8'hFF, 8'hAA}, x: {8'd4, 8'd3, 8'd2, 8'd1}, e0: 0,     e1: -10, e2: 0,    eidx: 0};
    // full-scale inputs
    tbl[4] = '{nw: {8'h55, 8'h00, 8'hFF}, x: {8'd255, 8'd255, 8'd255, 8'd255}, e0: -1020, e1: 0, e2: 1020, eidx: 2};
    // maximum in the middle lane
    tbl[5] = '{nw: {8'hFF, 8'h55, 8'h0D}, x: {8'd1, 8'd7, 8'd0, 8'd5}, e0: 5,     e1: 13,  e2: -13,  eidx: 1};

    rst = 1'b1;
    s_in_vec = '0; s_in_valid = 1'b0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_out_ready = 1'b0;
    l_in_vec = '0; l_in_valid = 1'b0; l_wr_en = 1'b0; l_wr_addr = '0; l_wr_data = '0; l_out_ready = 1'b0;
    lsel = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", longint'(s_in_ready), 0);
    chk("rst.wr_ready", longint'(s_wr_ready), 0);
    chk("rst.out_valid", longint'(s_out_valid), 0);
    chk("rst.out_idx", longint'(s_out_idx), 0);
    chk("rst.lane0", s_lane(0), 0);
    rst = 1'b0;
    #1 chk("rst_release.in_ready", longint'(s_in_ready), 1);
    chk("rst_release.l_in_ready", longint'(l_in_ready), 1);

    // ---- table-driven small vectors ----
    for (int v = 0; v < 6; v++) begin
      s_load(tbl[v].nw);
      s_start(tbl[v].x);
      s_wait(6, 0);
      s_check($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].eidx);
      s_release();
    end

    // ---- backpressure: result held, no new accept ----
    s_load(tbl[0].nw);
    s_start(tbl[0].x);
    s_wait(6, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_in_valid = (c == 5);
      s_in_vec   = 32'h09090909;
      #1;
      chk("bp.out_valid", longint'(s_out_valid), 1);
      chk("bp.in_ready", longint'(s_in_ready), 0);
      chk("bp.lane0", s_lane(0), 10);
      chk("bp.lane1", s_lane(1), -10);
      chk("bp.lane2", s_lane(2), 2);
      chk("bp.idx", longint'(s_out_idx), 0);
    end
    s_in_valid = 1'b0;
    $display("txn backpressure: held 20 cycles");
    s_release();
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp.no_phantom", longint'(s_out_valid), 0);
    end

    // ---- writes while busy are dropped ----
    s_start(tbl[0].x);
    s_write(2'd0, 6'b111111, 1'b0);       // lands on edge 1 of ACC
    s_wait(6, 1);
    s_check("busywr.cur", 10, -10, 2, 0);
    s_release();
    s_start(tbl[0].x);
    s_wait(6, 0);
    s_check("busywr.next", 10, -10, 2, 0);
    s_release();
    // same write in IDLE takes effect
    s_write(2'd0, 6'b111111, 1'b1);
    s_start(tbl[0].x);
    s_wait(6, 0);
    s_check("idlewr", 8, -10, 0, 0);
    s_release();
    // write on the accepting edge is visible to that transaction
    @(negedge clk);
    s_in_vec = tbl[0].x; s_in_valid = 1'b1;
    s_wr_en = 1'b1; s_wr_addr = 2'd0; s_wr_data = 6'b011101;
    #1 chk("acc_wr.wr_ready", longint'(s_wr_ready), 1);
    @(posedge clk);
    #1 s_in_valid = 1'b0; s_wr_en = 1'b0;
    s_wait(6, 0);
    s_check("acc_wr", 10, -10, 2, 0);
    s_release();

    // ---- reset mid-ACC ----
    s_start(tbl[0].x);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.in_ready", longint'(s_in_ready), 0);
    chk("midrst.wr_ready", longint'(s_wr_ready), 0);
    chk("midrst.out_valid", longint'(s_out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.after.in_ready", longint'(s_in_ready), 1);
    chk("midrst.after.out_valid", longint'(s_out_valid), 0);
    chk("midrst.after.idx", longint'(s_out_idx), 0);
    chk("midrst.after.lane0", s_lane(0), 0);
    chk("midrst.after.lane1", s_lane(1), 0);
    s_start(tbl[0].x);
    s_wait(6, 0);
    s_check("midrst.rerun", 10, -10, 2, 0);
    s_release();

    // ---- full-size unsigned: all +1, all inputs 255 ----
    lsel = 1'b0;
    for (int r = 0; r < 121; r++) l_write(7'(r), 32'h5555_5555);
    l_run("def", {121{8'hFF}}, 30855, 30855, 30855, 0);

    // ---- full-size signed: x=-128, n0 -1, n1 reserved, rest +1 ----
    lsel = 1'b1;
    for (int r = 0; r < 121; r++) l_write(7'(r), 32'h5555_555B);
    l_run("sgn", {121{8'h80}}, 15488, 0, -15488, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tcb_dense_argmax.md
Name: tcb_dense_argmax

Overview:
- Parametrised ternary-weight (TCB) fully-connected layer engine with a built-in sequential argmax.
- Accepts one N_IN-element input vector per transaction over valid/ready, then streams inputs one per cycle through N_OUT parallel accumulators.
- Scans the sums for the maximum and returns all raw sums plus the winning index.
- Replaces the fixed-size layer/comparator pairs. A runtime-loadable weight store lets one instance serve any layer shape up to its parameters.

Parameters:
N_IN, 121, input vector length (>=1)
N_OUT, 16, neuron count (>=1)
IN_W, 8, bits per input element
IN_SIGNED, 0, 1 = inputs two's complement, 0 = unsigned
ACC_W, IN_W+$clog2(N_IN)+1, signed accumulator width per neuron
IDX_W, max(1,$clog2(N_OUT)), argmax index width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_vec  in  N_IN*IN_W  input vector, element i at [i*IN_W +: IN_W]
in_valid  in  1  input vector offered
in_ready  out  1  engine idle, can accept
wr_en  in  1  weight row write strobe
wr_addr  in  $clog2(N_IN) (min 1)  input index of row
wr_data  in  2*N_OUT  ternary codes, neuron j at [2j +: 2]
wr_ready  out  1  write will be taken this cycle
out_vec  out  N_OUT*ACC_W  signed sums, neuron j at [j*ACC_W +: ACC_W]
out_idx  out  IDX_W  argmax neuron index
out_valid  out  1  result valid
out_ready  in  1  result consumed

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high.
- Ternary codes: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0, 2'b10 = 0 (reserved, must never inject a value).
- Weight store: N_IN x 2*N_OUT registers. NOT cleared by rst; contents survive reset.
  - wr_ready = (state==IDLE) && !rst.
  - A write occurs on the edge where wr_en && wr_ready.
  - wr_addr >= N_IN is ignored.
  - Writes while busy are dropped silently.
- States:
  - IDLE: in_ready=1.
    - On in_valid && in_ready: latch in_vec, clear all acc, i=0, go ACC.
    - If wr_en is also high on the same edge, the write still lands. It is visible to this transaction because row 0 is read from the next cycle on.
  - ACC: each cycle, for all j, acc[j] += w[i][j]*x[i], where x is sign- or zero-extended per IN_SIGNED.
    - i increments each cycle.
    - When i==N_IN-1, go ARG (or DONE if N_OUT==1), with best_idx=0, best_val=acc[0] after the final update, k=1.
  - ARG: each cycle, if acc[k] > best_val (signed, strict), take k.
    - Ties keep the lower index.
    - When k==N_OUT-1, go DONE.
  - DONE: out_valid=1; out_vec and out_idx held stable.
    - On out_ready, go IDLE.
    - in_ready=0 throughout (no overlap of transactions).
- Latency: out_valid rises N_IN+N_OUT-1 edges after the accepting edge. That is N_IN for N_OUT==1, and 136 at the defaults.
- Accumulators wrap modulo 2^ACC_W. The default ACC_W cannot overflow (max |sum| = N_IN*2^IN_W).
- out_vec and out_idx are meaningful only while out_valid=1. out_idx updates only in ARG.
- Reset (any state, including mid-ACC/ARG/DONE): next cycle state=IDLE, out_valid=0, all acc=0, out_idx=0, i=k=0. Any in-flight transaction is discarded. in_ready=0 and wr_ready=0 while rst is high.
- in_vec is sampled only on the accepting edge; later changes have no effect.

Decomposition:
- Shared package tcb_pkg:
  - ternary code localparams (TCB_ZERO, TCB_POS, TCB_NEG, TCB_RSVD)
  - state enum (IDLE, ACC, ARG, DONE)
  - function tcb_mul(code, x) returning the signed product
- One sub-module: tcb_weight_ram, the N_IN x 2*N_OUT register array with a gated write port and combinational row read on index i.

Test Plan:
1. Defaults. All rows written 16{2'b01}, in_vec all 8'd255. -> Every out_vec lane = 30855, out_idx=0 (tie → lowest), out_valid 136 edges after accept.
2. N_IN=4, N_OUT=3, x=[1,2,3,4]. Neuron0 all +1, neuron1 all -1, neuron2 codes [01,00,11,01]. -> Sums [10,-10,2], out_idx=0, latency 6. Swap neuron0 and neuron2 weights -> out_idx=2.
3. Backpressure. Hold out_ready=0 for 20 cycles and pulse in_valid. -> out_valid stays 1, outputs stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle, in_ready=1.
4. wr_en during ACC rewriting row 0 to all 2'b11. -> wr_ready=0, current and next results still use the old weights. Repeat the write in IDLE -> next result uses -1.
5. Assert rst 1 cycle mid-ACC. -> out_valid=0, in_ready=1 one cycle after rst drops. Weights retained: rerunning case 2 stimulus gives [10,-10,2].
6. IN_SIGNED=1, N_IN=121, all x=-128, neuron0 all 2'b11, neuron1 all 2'b10, rest 2'b01. -> Lanes [15488, 0, -15488...], out_idx=0. Reserved code contributes 0.
